// File: rtl/ram_burst_ctrl.sv
// Burst controller that streams write beats into a single-port RAM with a
// 1-cycle registered read, and returns read bursts through a 2-entry skid FIFO.
module ram_burst_ctrl #(
  parameter int BW    = 32,
  parameter int AW    = 10,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // command channel
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [AW-1:0]    cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  // write-beat stream
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [BW-1:0]    wr_data_i,
  // read-beat stream
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [BW-1:0]    rd_data_o,
  output logic             rd_last_o,
  output logic             busy_o,
  // RAM port
  output logic             ram_we_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [BW-1:0]    ram_wdata_o,
  input  logic [BW-1:0]    ram_rdata_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  localparam logic [AW-1:0]    ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             issue_left_q, issue_left_d;
  logic             infl_q;
  logic             infl_last_q, infl_last_d;

  logic [BW-1:0]    fifo_data_q [2];
  logic             fifo_last_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;

  logic             wr_fire;
  logic             pop;
  logic             issue;
  logic [1:0]       occ_after_pop;

  assign wr_fire = (state_q == S_WRITE) && wr_valid_i;
  assign pop     = rd_valid_o && rd_ready_i;

  // Occupancy is judged after this cycle's pop so a ready consumer sees one beat per cycle.
  assign occ_after_pop = count_q - {1'b0, pop};
  assign issue = (state_q == S_READ) && issue_left_q &&
                 ((occ_after_pop + {1'b0, infl_q}) < 2'd2);

  assign count_d = count_q + {1'b0, infl_q} - {1'b0, pop};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    issue_left_d = issue_left_q;
    infl_last_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d       = cmd_addr_i;
          cnt_d        = cmd_len_i;
          issue_left_d = !cmd_write_i;
          state_d      = cmd_write_i ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (wr_fire) begin
          addr_d = addr_q + ADDR_ONE;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - LEN_ONE;
          end
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_ONE;
          infl_last_d = (cnt_q == '0);
          if (cnt_q == '0) begin
            issue_left_d = 1'b0;
          end else begin
            cnt_d = cnt_q - LEN_ONE;
          end
        end
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      issue_left_q <= 1'b0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      issue_left_q <= issue_left_d;
      infl_q       <= issue;
      infl_last_q  <= infl_last_d;
      count_q      <= count_d;
      // The RAM presents the issued word one cycle after the issue.
      if (infl_q) begin
        fifo_data_q[wr_ptr_q] <= ram_rdata_i;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign wr_ready_o  = (state_q == S_WRITE);

  assign rd_valid_o  = (count_q != 2'd0);
  assign rd_data_o   = fifo_data_q[rd_ptr_q];
  assign rd_last_o   = rd_valid_o && fifo_last_q[rd_ptr_q];

  assign ram_we_o    = wr_fire;
  assign ram_addr_o  = (state_q == S_IDLE) ? '0 : addr_q;
  assign ram_wdata_o = wr_fire ? wr_data_i : '0;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl: a table of write/read bursts against a
// behavioural RAM, plus hand-written reset-mid-burst sequence.
module tb_ram_burst_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        busy;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;

  ram_burst_ctrl #(.BW(32), .AW(10), .LEN_W(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .rd_last_o   (rd_last),
    .busy_o      (busy),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else        ram_rdata     <= mem[ram_addr];
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [7:0]  len;
    logic [31:0] d0;
    bit          tog;       // toggle rd_ready 1/0
    bit          stall;     // drop wr_valid for one cycle at beat 1
    bit          pulse;     // pulse cmd_valid during the burst
    logic [9:0]  last_addr; // RAM address of the final write beat
    int          first_lat; // cycles from accept to first ram_we / rd_valid
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input bit wr, input logic [9:0] addr, input logic [7:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},      busy,      1'b0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_wr_ready"},  wr_ready,  1'b0);
    chk({tag, "_rd_valid"},  rd_valid,  1'b0);
    chk({tag, "_ram_we"},    ram_we,    1'b0);
    chk({tag, "_ram_addr"},  ram_addr,  10'h000);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int beat, c, first;
    bit stalled, do_stall;
    logic [9:0] ea;
    beat = 0; c = 0; first = -1; stalled = 0;
    send_cmd(v.wr, v.addr, v.len);
    if (v.wr) begin
      while (beat <= int'(v.len) && c < 1000) begin
        @(negedge clk); c++;
        cmd_valid = v.pulse && (c == 2);
        cmd_addr  = 10'h155; cmd_write = 1'b0;
        do_stall  = v.stall && (beat == 1) && !stalled;
        wr_valid  = !do_stall;
        wr_data   = v.d0 + beat;
        #1;
        if (cmd_valid) chk("cmd_ignored_wr", cmd_ready, 1'b0);
        if (do_stall) begin
          chk("stall_ram_we", ram_we, 1'b0);
          chk("stall_wr_ready", wr_ready, 1'b1);
          stalled = 1;
        end else begin
          ea = v.addr + beat[9:0];
          chk("wr_ready", wr_ready, 1'b1);
          chk("ram_we", ram_we, 1'b1);
          chk("ram_addr", ram_addr, ea);
          chk("ram_wdata", ram_wdata, v.d0 + beat);
          if (beat == 0) chk("wr_first_lat", c, v.first_lat);
          if (beat == int'(v.len)) chk("wr_last_addr", ram_addr, v.last_addr);
          beat++;
        end
      end
      chk("wr_beats", beat, int'(v.len) + 1);
      @(negedge clk);
      wr_valid = 1'b0; cmd_valid = 1'b0;
      #1;
      check_idle("wr_done");
    end else begin
      while (beat <= int'(v.len) && c < 2000) begin
        @(negedge clk); c++;
        cmd_valid = v.pulse && (c == 4);
        cmd_addr  = 10'h155; cmd_write = 1'b1;
        rd_ready  = v.tog ? (c % 2 == 1) : 1'b1;
        #1;
        if (cmd_valid) chk("cmd_ignored_rd", cmd_ready, 1'b0);
        chk("rd_no_write", ram_we, 1'b0);
        if (rd_valid && first < 0) begin
          first = c;
          chk("rd_first_lat", c, v.first_lat);
        end
        if (!v.tog && first > 0) chk("rd_sustained", rd_valid, 1'b1);
        if (rd_valid && rd_ready) begin
          chk("rd_data", rd_data, v.d0 + beat);
          chk("rd_last", rd_last, beat == int'(v.len));
          beat++;
        end
      end
      chk("rd_beats", beat, int'(v.len) + 1);
      @(negedge clk);
      rd_ready = 1'b1; cmd_valid = 1'b0;
      #1;
      check_idle("rd_done");
    end
    $display("txn %0d: %s addr=%03h len=%0d beats=%0d cycles=%0d",
             idx, v.wr ? "WRITE" : "READ ", v.addr, v.len, beat, c);
  endtask

  initial begin
    int beat;
    vec_t v;
    vecs[0] = '{1'b1, 10'h010, 8'd3,   32'h0000_00A0, 1'b0, 1'b0, 1'b0, 10'h013, 1};
    vecs[1] = '{1'b0, 10'h010, 8'd3,   32'h0000_00A0, 1'b0, 1'b0, 1'b1, 10'h013, 3};
    vecs[2] = '{1'b1, 10'h3FE, 8'd3,   32'h0000_00B0, 1'b0, 1'b0, 1'b0, 10'h001, 1};
    vecs[3] = '{1'b0, 10'h3FE, 8'd3,   32'h0000_00B0, 1'b0, 1'b0, 1'b0, 10'h001, 3};
    vecs[4] = '{1'b1, 10'h100, 8'd7,   32'h0000_00C0, 1'b0, 1'b1, 1'b1, 10'h107, 1};
    vecs[5] = '{1'b0, 10'h100, 8'd7,   32'h0000_00C0, 1'b1, 1'b0, 1'b0, 10'h107, 3};
    vecs[6] = '{1'b1, 10'h200, 8'd0,   32'h0000_00D0, 1'b0, 1'b0, 1'b0, 10'h200, 1};
    vecs[7] = '{1'b0, 10'h200, 8'd0,   32'h0000_00D0, 1'b0, 1'b0, 1'b0, 10'h200, 3};
    vecs[8] = '{1'b1, 10'h300, 8'd255, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 10'h3FF, 1};
    vecs[9] = '{1'b0, 10'h300, 8'd255, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 10'h3FF, 3};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("post_reset");
    chk("post_reset_rd_data", rd_data, 32'h0);
    chk("post_reset_rd_last", rd_last, 1'b0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset in the middle of an 8-beat read, after two beats have been taken.
    send_cmd(1'b0, 10'h100, 8'd7);
    beat = 0;
    for (int c = 1; c < 50 && beat < 2; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0; rd_ready = 1'b1;
      #1;
      if (rd_valid) begin
        chk("pre_rst_rd_data", rd_data, 32'h0000_00C0 + beat);
        beat++;
      end
    end
    chk("pre_rst_beats", beat, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_idle("mid_rst");
    chk("mid_rst_rd_data", rd_data, 32'h0);
    chk("mid_rst_rd_last", rd_last, 1'b0);
    rst_n = 1'b1;
    $display("txn reset: read addr=100 len=7 abandoned after %0d beats", beat);

    v = '{1'b0, 10'h010, 8'd0, 32'h0000_00A0, 1'b0, 1'b0, 1'b0, 10'h010, 3};
    run_vec(10, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
